rxemac_filter: RTL and testbench

- Receive-side counterpart of the transmit source-MAC inserter.
- Sits in the RX byte stream after preamble/CRC handling and before the packet buffer.
- Compares each packet's destination MAC (first 6 bytes) against the device hardware MAC. It forwards accepted packets whole through a fixed-latency delay line, and silently discards rejected or runt packets.

---
 rtl/rxemac_filter_pkg.sv | 48 ++++
 rtl/eth_byte_delay.sv | 52 +++++
 rtl/rxemac_filter.sv | 187 ++++++++++++++++++
 tb/tb_rxemac_filter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rxemac_filter_pkg.sv
// ---------------------------------------------------------------------------
// rxemac_filter_pkg
// Shared Ethernet receive-path definitions: MAC address geometry, the
// broadcast address, the filter state encoding and a helper that picks one
// on-the-wire byte out of a 48-bit MAC.
// No ports (package).
// ---------------------------------------------------------------------------
package rxemac_filter_pkg;

  // Number of bytes in a MAC address (destination field length).
  localparam int MAC_LEN = 6;

  // All-ones destination address.
  localparam logic [47:0] MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;

  // Depth of the {v,byte} delay line in front of the output register.
  // Must equal MAC_LEN so the accept decision is ready exactly when the
  // first byte of its packet reaches the head.
  localparam int DELAY_DEPTH = MAC_LEN;

  // Byte index of the last destination byte.
  localparam logic [2:0] LAST_ADDR_IDX = 3'(MAC_LEN - 1);

  // Receive filter states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    PASS = 2'd2,
    DROP = 2'd3
  } rx_filt_state_t;

  // Byte idx (0 = first on the wire) of a 48-bit MAC. Bits [47:40] go first.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac,
                                          input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      3'd5:    b = mac[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/eth_byte_delay.sv
// ---------------------------------------------------------------------------
// eth_byte_delay
// Fixed-depth shift register of {valid, byte} pairs for RX byte streams.
// A byte entering at edge k occupies the head after edge k+DEPTH-1.
//
// Ports:
//   i_clk       system clock
//   i_reset_n   synchronous active-low clear (all entries invalid, bytes 0)
//   i_v         input byte valid
//   i_byte      input byte
//   o_v         head-of-line valid
//   o_byte      head-of-line byte
//   o_sop_next  high when the next edge moves the first byte of a valid run
//               into the head (entry DEPTH-2 valid, head not valid)
// ---------------------------------------------------------------------------
module eth_byte_delay #(
  parameter int DEPTH = 6
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_v,
  input  logic [7:0] i_byte,
  output logic       o_v,
  output logic [7:0] o_byte,
  output logic       o_sop_next
);

  logic [DEPTH-1:0] r_v;
  logic [7:0]       r_byte [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_byte[i] <= 8'h00;
      end
    end else begin
      r_v       <= {r_v[DEPTH-2:0], i_v};
      r_byte[0] <= i_byte;
      for (int i = 1; i < DEPTH; i++) begin
        r_byte[i] <= r_byte[i-1];
      end
    end
  end

  assign o_v        = r_v[DEPTH-1];
  assign o_byte     = r_byte[DEPTH-1];
  // Packets are separated by at least one invalid slot, so a valid entry
  // behind an invalid head is always the first byte of a new run.
  assign o_sop_next = r_v[DEPTH-2] & ~r_v[DEPTH-1];

endmodule

// File: rtl/rxemac_filter.sv
// ---------------------------------------------------------------------------
// rxemac_filter
// Receive destination-MAC filter. Compares the first six bytes of each
// packet with the device MAC (plus optional broadcast / multicast accept)
// and forwards accepted packets unmodified with a fixed 6-clock latency.
// Rejected and runt (<6 byte) packets are discarded with a one-clock
// o_drop pulse.
//
// Parameters:
//   OPT_BROADCAST  accept FF:FF:FF:FF:FF:FF
//   OPT_MULTICAST  accept any destination whose first byte has bit 0 set
//
// Ports:
//   i_clk      system clock
//   i_reset_n  synchronous active-low reset
//   i_en       1 = filter, 0 = promiscuous (sampled at packet start)
//   i_hw_mac   device MAC, [47:40] first on the wire (latched while idle)
//   i_v        input byte valid, contiguous per packet
//   i_byte     input byte
//   o_v        forwarded byte valid
//   o_byte     forwarded byte
//   o_drop     one-clock pulse per discarded packet
// ---------------------------------------------------------------------------
module rxemac_filter
  import rxemac_filter_pkg::*;
#(
  parameter logic OPT_BROADCAST = 1'b1,
  parameter logic OPT_MULTICAST = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en,
  input  logic [47:0] i_hw_mac,
  input  logic        i_v,
  input  logic [7:0]  i_byte,
  output logic        o_v,
  output logic [7:0]  o_byte,
  output logic        o_drop
);

  // Filter state
  rx_filt_state_t r_state, w_state_next;
  logic [2:0]     r_count, w_count_next;
  logic           r_match_hw, w_match_hw_next;
  logic           r_match_bc, w_match_bc_next;
  logic           r_mcast, w_mcast_next;
  logic           r_en;
  logic [47:0]    r_hw;
  // i_v of the previous edge. Forced to 1 by reset so that a packet already
  // in flight when reset releases is not mistaken for a fresh packet start.
  logic           r_v_prev;

  logic           w_byte_hw_eq;
  logic           w_byte_bc_eq;
  logic           w_accept;
  logic           w_drop_next;
  logic           r_drop;

  // Output side
  logic           r_accept;
  logic           r_o_v;
  logic [7:0]     r_o_byte;
  logic           w_head_v;
  logic [7:0]     w_head_byte;
  logic           w_head_sop_next;

  eth_byte_delay #(
    .DEPTH(DELAY_DEPTH)
  ) u_delay (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_v        (i_v),
    .i_byte     (i_byte),
    .o_v        (w_head_v),
    .o_byte     (w_head_byte),
    .o_sop_next (w_head_sop_next)
  );

  // Per-byte compares against the address byte at the current position.
  // r_count is 0 in IDLE, so the same compare serves the first byte.
  assign w_byte_hw_eq = (i_byte == mac_byte(r_hw, r_count));
  assign w_byte_bc_eq = (i_byte == mac_byte(MAC_BROADCAST, r_count));

  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_match_hw_next = r_match_hw;
    w_match_bc_next = r_match_bc;
    w_mcast_next    = r_mcast;
    w_accept        = 1'b0;
    w_drop_next     = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_v) begin
          if (r_v_prev) begin
            // Tail of a packet that began before reset released.
            w_state_next = DROP;
          end else begin
            w_state_next    = ADDR;
            w_count_next    = 3'd1;
            w_match_hw_next = w_byte_hw_eq;
            w_match_bc_next = w_byte_bc_eq;
            w_mcast_next    = i_byte[0];
          end
        end
      end

      ADDR: begin
        if (!i_v) begin
          // Runt: ended before the destination was complete.
          w_state_next = IDLE;
          w_count_next = 3'd0;
          w_drop_next  = 1'b1;
        end else begin
          w_count_next    = r_count + 3'd1;
          w_match_hw_next = r_match_hw & w_byte_hw_eq;
          w_match_bc_next = r_match_bc & w_byte_bc_eq;
          if (r_count == LAST_ADDR_IDX) begin
            w_accept = !r_en
                     | w_match_hw_next
                     | (OPT_BROADCAST & w_match_bc_next)
                     | (OPT_MULTICAST & r_mcast);
            w_count_next = 3'd0;
            w_state_next = w_accept ? PASS : DROP;
            w_drop_next  = !w_accept;
          end
        end
      end

      PASS: begin
        if (!i_v) w_state_next = IDLE;
      end

      DROP: begin
        if (!i_v) w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
        w_count_next = 3'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_count    <= 3'd0;
      r_match_hw <= 1'b0;
      r_match_bc <= 1'b0;
      r_mcast    <= 1'b0;
      r_en       <= 1'b0;
      r_hw       <= 48'h0;
      r_v_prev   <= 1'b1;
      r_drop     <= 1'b0;
      r_accept   <= 1'b0;
      r_o_v      <= 1'b0;
      r_o_byte   <= 8'h00;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_match_hw <= w_match_hw_next;
      r_match_bc <= w_match_bc_next;
      r_mcast    <= w_mcast_next;
      r_v_prev   <= i_v;
      r_drop     <= w_drop_next;

      // MAC only follows the input between packets; en is taken with byte 0.
      if (r_state == IDLE && !i_v) r_hw <= i_hw_mac;
      if (r_state == IDLE && i_v)  r_en <= i_en;

      // The decision for a packet is produced on the same edge that moves
      // its byte 0 into the head, because the delay depth equals MAC_LEN.
      // Runts and post-reset tails have no decision, so w_accept is 0.
      if (w_head_sop_next) r_accept <= w_accept;

      r_o_v <= w_head_v & r_accept;
      if (w_head_v) r_o_byte <= w_head_byte;
    end
  end

  assign o_v    = r_o_v;
  assign o_byte = r_o_byte;
  assign o_drop = r_drop;

endmodule

// File: tb/tb_rxemac_filter.sv
// ---------------------------------------------------------------------------
// tb_rxemac_filter
// Two instances (default options, and OPT_MULTICAST=0) share one stimulus.
// A packet-level reference model decides accept/drop per packet and fills
// per-cycle expectation tables for o_v, o_byte and o_drop.
// ---------------------------------------------------------------------------
module tb_rxemac_filter;

  localparam int MAXC = 8192;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_v;
  logic [7:0]  in_byte;
  logic        en;
  logic [47:0] hw_mac;
  logic        ov0, od0, ov1, od1;
  logic [7:0]  ob0, ob1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  bit         exp_v [2][MAXC];
  logic [7:0] exp_b [2][MAXC];
  bit         exp_d [2][MAXC];

  logic [47:0] mac;
  bit          need_latch;
  int          pkt_no = 0;

  always #5 clk = ~clk;

  rxemac_filter u_dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_en      (en),
    .i_hw_mac  (hw_mac),
    .i_v       (in_v),
    .i_byte    (in_byte),
    .o_v       (ov0),
    .o_byte    (ob0),
    .o_drop    (od0)
  );

  rxemac_filter #(
    .OPT_MULTICAST(1'b0)
  ) u_dut_nomc (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_en      (en),
    .i_hw_mac  (hw_mac),
    .i_v       (in_v),
    .i_byte    (in_byte),
    .o_v       (ov1),
    .o_byte    (ob1),
    .o_drop    (od1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the expectation tables.
  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      check("o_v_mc",    32'(ov0), 32'(exp_v[0][cyc]));
      check("o_drop_mc", 32'(od0), 32'(exp_d[0][cyc]));
      if (exp_v[0][cyc]) check("o_byte_mc", 32'(ob0), 32'(exp_b[0][cyc]));
      check("o_v_nomc",    32'(ov1), 32'(exp_v[1][cyc]));
      check("o_drop_nomc", 32'(od1), 32'(exp_d[1][cyc]));
      if (exp_v[1][cyc]) check("o_byte_nomc", 32'(ob1), 32'(exp_b[1][cyc]));
    end
  end

  // Called at a falling edge; drives one clock and returns at the next
  // falling edge. cyc numbers the rising edge that sampled these inputs.
  task automatic tick(input logic v, input logic [7:0] b, input logic rstn);
    in_v    = v;
    in_byte = b;
    reset_n = rstn;
    @(posedge clk);
    cyc = cyc + 1;
    @(negedge clk);
  endtask

  // Packet-level acceptance rule; instance 1 has multicast accept disabled.
  function automatic bit model_accept(input int d, input logic [47:0] dst,
                                      input int len, input bit pen);
    bit mc_opt;
    mc_opt = (d == 0);
    if (len < 6) return 1'b0;
    return !pen || (dst == mac) || (dst == 48'hFFFF_FFFF_FFFF) || (mc_opt && dst[40]);
  endfunction

  task automatic send_pkt(input logic [47:0] dst, input int len, input bit pen,
                          input int gap_in, input int rst_at);
    logic [7:0] pkt [$];
    int  s, r, gap;
    bit  acc [2];
    gap = gap_in;
    // A new MAC (or one lost to reset) is only picked up on an idle edge
    // while the filter is already IDLE, which needs two gap clocks.
    if (need_latch && gap < 2) gap = 2;
    hw_mac = mac;
    en     = pen;
    for (int g = 0; g < gap; g++) tick(1'b0, 8'($urandom), 1'b1);
    need_latch = 1'b0;

    for (int j = 0; j < len; j++) begin
      if (j < 6) pkt.push_back(dst[47-8*j -: 8]);
      else       pkt.push_back(8'($urandom));
    end

    s = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      acc[d] = model_accept(d, dst, len, pen);
      if (len < 6) begin
        exp_d[d][s+len] = 1'b1;
      end else if (!acc[d]) begin
        exp_d[d][s+5] = 1'b1;
      end else begin
        for (int j = 0; j < len; j++) begin
          exp_v[d][s+6+j] = 1'b1;
          exp_b[d][s+6+j] = pkt[j];
        end
      end
    end
    pkt_no++;
    $display("[TB] pkt %0d: dst=%012h len=%0d en=%0d rst_at=%0d expect accept mc=%0d nomc=%0d",
             pkt_no, dst, len, pen, rst_at, acc[0], acc[1]);

    for (int j = 0; j < len; j++) begin
      if (j == rst_at) begin
        // Reset wipes everything still in flight and the packet tail.
        r = cyc + 1;
        for (int d = 0; d < 2; d++) begin
          for (int t = r; t < r + len + 12 && t < MAXC; t++) begin
            exp_v[d][t] = 1'b0;
            exp_d[d][t] = 1'b0;
          end
        end
        tick(1'b1, pkt[j], 1'b0);
        need_latch = 1'b1;
      end else begin
        tick(1'b1, pkt[j], 1'b1);
      end
      if (j == 0) begin
        // MAC and enable must be ignored once the packet has started.
        hw_mac = {16'($urandom), 32'($urandom)};
        en     = 1'($urandom);
      end
    end
    hw_mac = mac;
    en     = pen;
  endtask

  initial begin
    logic [47:0] dst, one;
    int          len, gap, rst_at, sel;
    bit          pen;

    reset_n = 1'b0;
    in_v    = 1'b0;
    in_byte = 8'h00;
    en      = 1'b1;
    hw_mac  = 48'h0;
    mac     = 48'h02_00_0A_0B_0C_0D;
    one     = 48'h1;
    need_latch = 1'b1;

    tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'hA5, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    check("rst_o_v_mc",      32'(ov0), 32'd0);
    check("rst_o_byte_mc",   32'(ob0), 32'd0);
    check("rst_o_drop_mc",   32'(od0), 32'd0);
    check("rst_o_v_nomc",    32'(ov1), 32'd0);
    check("rst_o_byte_nomc", 32'(ob1), 32'd0);
    check("rst_o_drop_nomc", 32'(od1), 32'd0);
    chk_en = 1'b1;

    // Directed cases
    send_pkt(mac, 64, 1'b1, 2, -1);                       // unicast match
    send_pkt(48'h02_00_0A_0B_0C_0E, 64, 1'b1, 1, -1);     // last-byte mismatch
    send_pkt(48'hFF_FF_FF_FF_FF_FF, 20, 1'b1, 1, -1);     // broadcast
    send_pkt(48'h01_00_5E_00_00_01, 20, 1'b1, 1, -1);     // multicast
    send_pkt(mac, 4, 1'b1, 1, -1);                        // runt
    send_pkt(mac, 1, 1'b1, 1, -1);                        // 1-byte runt
    send_pkt(mac, 5, 1'b1, 1, -1);                        // 5-byte runt
    send_pkt(mac, 6, 1'b1, 1, -1);                        // minimum length
    send_pkt(48'h02_00_0A_0B_0C_0E, 20, 1'b0, 1, -1);     // promiscuous
    send_pkt(48'h12_34_56_78_9A_BC, 10, 1'b1, 1, -1);     // back-to-back: reject
    send_pkt(mac, 10, 1'b1, 1, -1);                       //               accept
    send_pkt(mac, 40, 1'b1, 1, 20);                       // reset mid-packet
    send_pkt(mac, 30, 1'b1, 1, -1);                       // filtered normally after

    // Randomized traffic
    for (int p = 0; p < 80; p++) begin
      if ($urandom_range(0, 7) == 0) begin
        mac     = {16'($urandom), 32'($urandom)};
        mac[40] = 1'b0;
        need_latch = 1'b1;
      end
      sel = $urandom_range(0, 4);
      case (sel)
        0, 1:    dst = mac;
        2:       dst = mac ^ (one << (8 * $urandom_range(0, 5)));
        3:       dst = 48'hFF_FF_FF_FF_FF_FF;
        default: dst = {16'($urandom), 32'($urandom)};
      endcase
      len    = $urandom_range(1, 30);
      pen    = ($urandom_range(0, 7) != 0);
      gap    = $urandom_range(1, 3);
      rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
      send_pkt(dst, len, pen, gap, rst_at);
    end

    for (int g = 0; g < 12; g++) tick(1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
